alu_vector_checker: RTL and testbench

ALU_VECTOR_CHECKER -- requirements
Module: alu_vector_checker

---
 rtl/alu_vector_checker.sv | 181 ++++++++++++++++++
 tb/tb_alu_vector_checker.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_vector_checker.sv
// Replays stored {ctrl, A, B, expected} vectors into an ALU under test and compares its results.
// Optional first-mismatch data capture is enabled by defining VEC_CHECKER_FAILLOG_EN.
module alu_vector_checker #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 11,
  parameter int DEPTH  = 128,
  parameter int LAT    = 1,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1),
  localparam int VW = CTRL_W + 3 * DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_vec_we,
  input  logic [AW-1:0]     i_vec_waddr,
  input  logic [VW-1:0]     i_vec_wdata,
  input  logic [CW-1:0]     i_num_vectors,
  input  logic              i_start,
  input  logic              i_stop_on_fail,
  output logic              o_dut_valid,
  output logic [CTRL_W-1:0] o_dut_ctrl,
  output logic [DATA_W-1:0] o_dut_a,
  output logic [DATA_W-1:0] o_dut_b,
  input  logic [DATA_W-1:0] i_dut_out,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [CW-1:0]     o_fail_count,
  output logic [AW-1:0]     o_first_fail_idx,
  output logic [DATA_W-1:0] o_first_fail_got,
  output logic [DATA_W-1:0] o_first_fail_exp,
  output logic [1:0]        o_dbg_state
);

  // Handshake: the DUT sees one vector per cycle while o_dut_valid=1 and has no backpressure;
  // i_dut_out is sampled exactly LAT cycles after the matching o_dut_valid cycle.

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t              r_state;
  state_t              w_next;
  logic [VW-1:0]       r_mem [DEPTH];
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       r_num;
  logic                r_stop;
  logic                r_halt;
  logic [DATA_W-1:0]   r_exp_cur;
  logic [AW-1:0]       r_idx_cur;
  logic [LAT-1:0]      r_pv;
  logic [DATA_W-1:0]   r_pexp [LAT];
  logic [AW-1:0]       r_pidx [LAT];
  logic [VW-1:0]       w_rd;
  logic                w_idle_like;
  logic                w_start;
  logic [CW-1:0]       w_num_clamped;
  logic                w_mismatch;
  logic                w_halt;
  logic                w_issue;
  logic                w_last;
  logic                w_pipe_busy;

  assign w_idle_like   = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_start       = i_start && w_idle_like;
  assign w_num_clamped = (i_num_vectors > DEPTH_C) ? DEPTH_C : i_num_vectors;
  assign w_mismatch    = r_pv[LAT-1] && (i_dut_out != r_pexp[LAT-1]);
  // A mismatch compared this cycle already blocks the issue decision made in the same cycle.
  assign w_halt        = r_halt || (r_stop && w_mismatch);
  assign w_issue       = (r_state == S_ISSUE) && !w_halt;
  assign w_last        = w_issue && ((r_cnt + CW'(1)) == r_num);
  assign w_pipe_busy   = o_dut_valid || (|r_pv);
  assign w_rd          = r_mem[r_cnt[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_vec_we && w_idle_like) r_mem[i_vec_waddr] <= i_vec_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (i_start) w_next = (w_num_clamped == '0) ? S_DONE : S_ISSUE;
      S_ISSUE:        if (w_halt || w_last) w_next = S_DRAIN;
      S_DRAIN:        if (!w_pipe_busy) w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_dut_valid <= 1'b0;
      o_dut_ctrl  <= '0;
      o_dut_a     <= '0;
      o_dut_b     <= '0;
      r_exp_cur   <= '0;
      r_idx_cur   <= '0;
      r_cnt       <= '0;
      r_num       <= '0;
      r_stop      <= 1'b0;
      r_halt      <= 1'b0;
    end else begin
      o_dut_valid <= w_issue;
      o_dut_ctrl  <= w_issue ? w_rd[VW-1 -: CTRL_W] : '0;
      o_dut_a     <= w_issue ? w_rd[3*DATA_W-1 -: DATA_W] : '0;
      o_dut_b     <= w_issue ? w_rd[2*DATA_W-1 -: DATA_W] : '0;
      r_exp_cur   <= w_issue ? w_rd[DATA_W-1:0] : '0;
      r_idx_cur   <= w_issue ? r_cnt[AW-1:0] : '0;
      if (w_start) begin
        r_cnt  <= '0;
        r_num  <= w_num_clamped;
        r_stop <= i_stop_on_fail;
        r_halt <= 1'b0;
      end else begin
        if (w_issue) r_cnt <= r_cnt + CW'(1);
        if (r_stop && w_mismatch) r_halt <= 1'b1;
      end
    end
  end

  // Expected value and index ride alongside the DUT latency.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pv <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_pexp[i] <= '0;
        r_pidx[i] <= '0;
      end
    end else begin
      r_pv[0]   <= o_dut_valid;
      r_pexp[0] <= r_exp_cur;
      r_pidx[0] <= r_idx_cur;
      for (int i = 1; i < LAT; i++) begin
        r_pv[i]   <= r_pv[i-1];
        r_pexp[i] <= r_pexp[i-1];
        r_pidx[i] <= r_pidx[i-1];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_fail_count     <= '0;
      o_first_fail_idx <= '0;
    end else if (w_start) begin
      o_fail_count     <= '0;
      o_first_fail_idx <= '0;
    end else if (w_mismatch) begin
      if (o_fail_count != '1) o_fail_count <= o_fail_count + CW'(1);
      if (o_fail_count == '0) o_first_fail_idx <= r_pidx[LAT-1];
    end
  end

`ifdef VEC_CHECKER_FAILLOG_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_first_fail_got <= '0;
      o_first_fail_exp <= '0;
    end else if (w_start) begin
      o_first_fail_got <= '0;
      o_first_fail_exp <= '0;
    end else if (w_mismatch && (o_fail_count == '0)) begin
      o_first_fail_got <= i_dut_out;
      o_first_fail_exp <= r_pexp[LAT-1];
    end
  end
`else
  assign o_first_fail_got = '0;
  assign o_first_fail_exp = '0;
`endif

  assign o_busy      = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign o_done      = (r_state == S_DONE);
  assign o_pass      = (r_state == S_DONE) && (o_fail_count == '0);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_vector_checker.sv
// Bench for alu_vector_checker: behavioural ALU with LAT-cycle latency, run-scenario table,
// issue-order scoreboard, plus mid-run reset and ignored start/write sequences.
module tb_alu_vector_checker;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 11;
  localparam int DEPTH  = 16;
  localparam int LAT    = 3;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int VW     = CTRL_W + 3 * DATA_W;
  localparam int IW     = CTRL_W + 2 * DATA_W;
  localparam logic [31:0] BAD = 32'hDEADBEEF;

  logic              clk = 1'b0;
  logic              rst;
  logic              vec_we;
  logic [AW-1:0]     vec_waddr;
  logic [VW-1:0]     vec_wdata;
  logic [CW-1:0]     num_vectors;
  logic              start;
  logic              stop_on_fail;
  logic              dut_valid;
  logic [CTRL_W-1:0] dut_ctrl;
  logic [DATA_W-1:0] dut_a;
  logic [DATA_W-1:0] dut_b;
  logic [DATA_W-1:0] dut_out;
  logic              busy;
  logic              done;
  logic              pass;
  logic [CW-1:0]     fail_count;
  logic [AW-1:0]     first_fail_idx;
  logic [DATA_W-1:0] first_fail_got;
  logic [DATA_W-1:0] first_fail_exp;
  logic [1:0]        dbg_state;

  alu_vector_checker #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH), .LAT(LAT)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_vec_we(vec_we), .i_vec_waddr(vec_waddr),
    .i_vec_wdata(vec_wdata), .i_num_vectors(num_vectors), .i_start(start),
    .i_stop_on_fail(stop_on_fail), .o_dut_valid(dut_valid), .o_dut_ctrl(dut_ctrl),
    .o_dut_a(dut_a), .o_dut_b(dut_b), .i_dut_out(dut_out), .o_busy(busy), .o_done(done),
    .o_pass(pass), .o_fail_count(fail_count), .o_first_fail_idx(first_fail_idx),
    .o_first_fail_got(first_fail_got), .o_first_fail_exp(first_fail_exp),
    .o_dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] alu(input logic [10:0] c, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (c[3:1])
      3'b000:  return c[0] ? a - b : a + b;
      3'b111:  return a & b;
      3'b110:  return a | b;
      3'b100:  return a ^ b;
      3'b001:  return a << b[4:0];
      3'b101:  if (c[0]) return sa >>> b[4:0]; else return a >> b[4:0];
      default: return a + b;
    endcase
  endfunction

  // ALU under test: result appears LAT cycles after its inputs are valid.
  logic [31:0] alu_pipe [LAT];
  always @(posedge clk) begin
    alu_pipe[0] <= alu(dut_ctrl, dut_a, dut_b);
    for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign dut_out = alu_pipe[LAT-1];

  logic [10:0] tb_ctrl [DEPTH];
  logic [31:0] tb_a    [DEPTH];
  logic [31:0] tb_b    [DEPTH];

  // Scoreboard: expected issue records and monitor
  logic [IW-1:0] exp_q[$];
  int mon_issued = 0;
  int mon_rises  = 0;
  logic mon_prev = 1'b0;

  always @(negedge clk) begin
    if (dut_valid) begin
      mon_issued++;
      if (!mon_prev) mon_rises++;
      if (exp_q.size() == 0) begin
        check("issue_extra", {dut_ctrl, dut_a, dut_b}, '1);
      end else begin
        check("issue_seq", {dut_ctrl, dut_a, dut_b}, exp_q.pop_front());
      end
    end else if (!rst) begin
      check("idle_bus_zero", {dut_ctrl, dut_a, dut_b}, '0);
    end
    mon_prev = dut_valid;
  end

  // Driver tasks
  task automatic write_storage(input logic [15:0] mask);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      vec_we    = 1'b1;
      vec_waddr = AW'(i);
      vec_wdata = {tb_ctrl[i], tb_a[i], tb_b[i], mask[i] ? BAD : alu(tb_ctrl[i], tb_a[i], tb_b[i])};
    end
    @(negedge clk);
    vec_we = 1'b0;
  endtask

  task automatic start_run(input int n, input bit stop, input int exp_issued);
    for (int i = 0; i < exp_issued; i++) exp_q.push_back({tb_ctrl[i], tb_a[i], tb_b[i]});
    mon_issued = 0;
    mon_rises  = 0;
    @(negedge clk);
    start        = 1'b1;
    num_vectors  = CW'(n);
    stop_on_fail = stop;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 400; k++) begin
      if (done) break;
      @(negedge clk);
    end
    if (k == 400) check("done_timeout", 0, 1);
  endtask

  task automatic finish_run(input int exp_issued, input int fails, input int first, input bit exp_pass);
    logic [31:0] e_got, e_exp;
    wait_done();
    @(negedge clk);
    e_got = '0;
    e_exp = '0;
`ifdef VEC_CHECKER_FAILLOG_EN
    if (fails > 0) begin
      e_got = alu(tb_ctrl[first], tb_a[first], tb_b[first]);
      e_exp = BAD;
    end
`endif
    check("issued", mon_issued, exp_issued);
    check("issue_bursts", mon_rises, (exp_issued > 0) ? 1 : 0);
    check("done_state", {done, busy}, 2'b10);
    check("fail_count", fail_count, fails);
    check("pass", pass, exp_pass);
    check("first_idx", first_fail_idx, first);
    check("first_got", first_fail_got, e_got);
    check("first_exp", first_fail_exp, e_exp);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic run_case(input int n, input bit stop, input int exp_issued, input int fails,
                          input int first, input bit exp_pass);
    start_run(n, stop, exp_issued);
    if (n == 0) check("zero_done_next", {done, pass, busy}, 3'b110);
    else        check("busy_after_start", {busy, done}, 2'b10);
    finish_run(exp_issued, fails, first, exp_pass);
  endtask

  typedef struct {
    int          n;
    bit          stop;
    logic [15:0] mask;
    int          issued;
    int          fails;
    int          first;
    bit          pass;
  } case_t;

  case_t tbl [9];
  logic [2:0] op_tab [8];

  initial begin
    int k;
    rst = 1'b1; vec_we = 1'b0; vec_waddr = '0; vec_wdata = '0;
    num_vectors = '0; start = 1'b0; stop_on_fail = 1'b0;

    op_tab = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b100, 3'b001, 3'b101, 3'b101};
    for (int i = 0; i < DEPTH; i++) begin
      k = $urandom_range(0, 7);
      tb_ctrl[i] = {7'b0110011, op_tab[k], (k == 1 || k == 7) ? 1'b1 : 1'b0};
      tb_a[i]    = $urandom;
      tb_b[i]    = $urandom;
    end
    tb_ctrl[0] = {7'b0110011, 3'b000, 1'b0};
    tb_a[0] = 32'd1;
    tb_b[0] = 32'd2;

    // Stop-on-fail issue ends at index first+LAT: the mismatch blocks the issue decided in its compare cycle.
    tbl[0] = '{n: 0,  stop: 0, mask: 16'h0000, issued: 0,  fails: 0, first: 0,  pass: 1};
    tbl[1] = '{n: 4,  stop: 0, mask: 16'h0000, issued: 4,  fails: 0, first: 0,  pass: 1};
    tbl[2] = '{n: 10, stop: 0, mask: 16'h0020, issued: 10, fails: 1, first: 5,  pass: 0};
    tbl[3] = '{n: 8,  stop: 1, mask: 16'h000C, issued: 6,  fails: 2, first: 2,  pass: 0};
    tbl[4] = '{n: 8,  stop: 0, mask: 16'h000C, issued: 8,  fails: 2, first: 2,  pass: 0};
    tbl[5] = '{n: 20, stop: 0, mask: 16'h0000, issued: 16, fails: 0, first: 0,  pass: 1};
    tbl[6] = '{n: 16, stop: 0, mask: 16'h8001, issued: 16, fails: 2, first: 0,  pass: 0};
    tbl[7] = '{n: 16, stop: 1, mask: 16'h8000, issued: 16, fails: 1, first: 15, pass: 0};
    tbl[8] = '{n: 1,  stop: 1, mask: 16'h0001, issued: 1,  fails: 1, first: 0,  pass: 0};

    repeat (3) @(negedge clk);
    check("reset_state", {busy, done, pass, dut_valid, dbg_state}, '0);
    check("reset_fail_count", fail_count, 0);
    rst = 1'b0;
    write_storage(16'h0000);
    check("idle_after_writes", {busy, done}, 2'b00);

    for (int t = 0; t < 9; t++) begin
      write_storage(tbl[t].mask);
      run_case(tbl[t].n, tbl[t].stop, tbl[t].issued, tbl[t].fails, tbl[t].first, tbl[t].pass);
    end

    // Reset while vector 7 is on the bus, then rerun from untouched storage.
    write_storage(16'h0000);
    start_run(12, 1'b0, 12);
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (mon_issued >= 8) break;
    end
    check("reach_vec7", mon_issued, 8);
    #1 rst = 1'b1;
    #1;
    check("midrun_reset", {busy, dut_valid, done, dbg_state}, '0);
    check("midrun_reset_fails", fail_count, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    run_case(12, 1'b0, 12, 0, 0, 1'b1);

    // Write during ISSUE and start during DRAIN must both be dropped.
    start_run(6, 1'b0, 6);
    vec_we    = 1'b1;
    vec_waddr = AW'(2);
    vec_wdata = {tb_ctrl[2], tb_a[2], tb_b[2], BAD};
    @(negedge clk);
    vec_we = 1'b0;
    for (k = 0; k < 100; k++) begin
      if (dbg_state == 2'd2) break;
      @(negedge clk);
    end
    check("reach_drain", dbg_state, 2'd2);
    start       = 1'b1;
    num_vectors = CW'(1);
    @(negedge clk);
    start = 1'b0;
    finish_run(6, 0, 0, 1'b1);
    run_case(6, 1'b0, 6, 0, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
